voice_allocator: RTL

Polyphonic voice scheduler between the Avalon command register and the bank of oscillator pipelines. It accepts note-on, note-off and all-off commands and assigns each note-on to a free voice. When every voice is busy it steals the least-recently-allocated voice. It drives per-voice load pulses, gates and release pulses, and carries a shared note/velocity bus to the pipelines.

---
 rtl/synth_pkg.sv | 31 +++
 rtl/voice_lru.sv | 47 ++++
 rtl/voice_allocator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synthesiser control path.
// Holds command opcodes, command word field positions and FSM encodings.
// Pure declarations; no logic, no latency, no backpressure.
package synth_pkg;

   // Command word layout: [15:14] op, [13:7] note, [6:0] velocity
   localparam int CMD_W   = 16;
   localparam int OP_HI   = 15;
   localparam int OP_LO   = 14;
   localparam int NOTE_HI = 13;
   localparam int NOTE_LO = 7;
   localparam int VEL_HI  = 6;
   localparam int VEL_LO  = 0;

   localparam int NOTE_W_DEF = 7;
   localparam int VEL_W_DEF  = 7;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_ON     = 2'b01,
      OP_OFF    = 2'b10,
      OP_ALLOFF = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/voice_lru.sv
// LRU rank array: rank 0 = most recently allocated, NVOICES-1 = oldest.
// Touch takes effect on the next edge; oldest index is combinational.
// No backpressure; a touch is accepted every cycle it is presented.
module voice_lru #(
   parameter int NVOICES = 8,
   parameter int IW      = $clog2(NVOICES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_touch_vld,
   input  logic [IW-1:0] i_touch_idx,
   output logic [IW-1:0] o_oldest_idx
);

   logic [IW-1:0] r_age [NVOICES];
   logic [IW-1:0] w_touch_age;

   assign w_touch_age = r_age[i_touch_idx];

   // Move the touched voice to rank 0; everything that was newer ages by one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NVOICES; i++) begin
            r_age[i] <= IW'(i);
         end
      end else if (i_touch_vld) begin
         for (int i = 0; i < NVOICES; i++) begin
            if (IW'(i) == i_touch_idx) begin
               r_age[i] <= '0;
            end else if (r_age[i] < w_touch_age) begin
               r_age[i] <= r_age[i] + IW'(1);
            end
         end
      end
   end

   // Ranks are a permutation, so exactly one voice holds the top rank
   always_comb begin
      o_oldest_idx = '0;
      for (int i = 0; i < NVOICES; i++) begin
         if (r_age[i] == IW'(NVOICES - 1)) begin
            o_oldest_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off/all-off commands onto voices.
// Note commands: pulses NVOICES+1 edges after acceptance; all-off: 1 edge.
// cmd_ready low while a command is in flight; high again in the pulse cycle.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NVOICES = 8,
   parameter int NOTE_W  = NOTE_W_DEF,
   parameter int VEL_W   = VEL_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CMD_W-1:0]   cmd_data,
   output logic [NVOICES-1:0] voice_load,
   output logic [NOTE_W-1:0]  voice_note,
   output logic [VEL_W-1:0]   voice_vel,
   output logic [NVOICES-1:0] voice_gate,
   output logic [NVOICES-1:0] voice_release,
   output logic               voice_stolen,
   output logic [4:0]         active_count
);

   localparam int IW = $clog2(NVOICES);

   state_t              r_state;
   state_t              w_next_state;
   op_t                 r_op;
   logic [NOTE_W-1:0]   r_cmd_note;
   logic [VEL_W-1:0]    r_cmd_vel;

   logic [IW-1:0]       r_idx;
   logic                r_match_vld;
   logic [IW-1:0]       r_match_idx;
   logic                r_free_vld;
   logic [IW-1:0]       r_free_idx;

   logic [NVOICES-1:0]  r_gate;
   logic [NOTE_W-1:0]   r_note [NVOICES];

   logic [NVOICES-1:0]  r_load;
   logic [NVOICES-1:0]  r_release;
   logic                r_stolen;
   logic [NOTE_W-1:0]   r_vnote;
   logic [VEL_W-1:0]    r_vvel;

   logic                w_accept;
   op_t                 w_cmd_op;
   logic [NOTE_W-1:0]   w_cmd_note;
   logic [VEL_W-1:0]    w_cmd_vel;
   logic                w_hit;
   logic                w_is_free;
   logic [IW-1:0]       w_oldest;
   logic [IW-1:0]       w_target;
   logic                w_steal;
   logic                w_touch;
   logic [4:0]          w_active;

   assign w_cmd_op   = op_t'(cmd_data[OP_HI:OP_LO]);
   assign w_cmd_note = NOTE_W'(cmd_data[NOTE_HI:NOTE_LO]);
   assign w_cmd_vel  = VEL_W'(cmd_data[VEL_HI:VEL_LO]);
   assign w_accept   = cmd_valid && cmd_ready;

   assign w_hit     = r_gate[r_idx] && (r_note[r_idx] == r_cmd_note);
   assign w_is_free = !r_gate[r_idx];

   // Retrigger beats a free voice, which beats stealing the oldest
   assign w_steal  = !r_match_vld && !r_free_vld;
   assign w_target = r_match_vld ? r_match_idx :
                     r_free_vld  ? r_free_idx  : w_oldest;
   assign w_touch  = (r_state == ST_COMMIT) && (r_op == OP_ON);

   voice_lru #(
      .NVOICES (NVOICES),
      .IW      (IW)
   ) u_lru (
      .clk          (clk),
      .reset        (reset),
      .i_touch_vld  (w_touch),
      .i_touch_idx  (w_target),
      .o_oldest_idx (w_oldest)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and handshake; nop is consumed in IDLE without leaving it
   always_comb begin
      w_next_state = r_state;
      cmd_ready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (w_cmd_op)
                  OP_ON, OP_OFF: w_next_state = ST_SCAN;
                  OP_ALLOFF:     w_next_state = ST_COMMIT;
                  default:       w_next_state = ST_IDLE;
               endcase
            end
         end
         ST_SCAN: begin
            if (r_idx == IW'(NVOICES - 1)) begin
               w_next_state = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Capture the command at acceptance; velocity-0 note-on becomes note-off
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op       <= OP_NOP;
         r_cmd_note <= '0;
         r_cmd_vel  <= '0;
      end else if (w_accept) begin
         r_op       <= (w_cmd_op == OP_ON && w_cmd_vel == '0) ? OP_OFF : w_cmd_op;
         r_cmd_note <= w_cmd_note;
         r_cmd_vel  <= w_cmd_vel;
      end
   end

   // Walk one voice per cycle keeping the lowest matching and lowest free index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx       <= '0;
         r_match_vld <= 1'b0;
         r_match_idx <= '0;
         r_free_vld  <= 1'b0;
         r_free_idx  <= '0;
      end else if (w_accept) begin
         r_idx       <= '0;
         r_match_vld <= 1'b0;
         r_free_vld  <= 1'b0;
      end else if (r_state == ST_SCAN) begin
         r_idx <= r_idx + IW'(1);
         if (w_hit && !r_match_vld) begin
            r_match_vld <= 1'b1;
            r_match_idx <= r_idx;
         end
         if (w_is_free && !r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
         end
      end
   end

   // Apply the command to voice state and register the one-cycle pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gate    <= '0;
         r_load    <= '0;
         r_release <= '0;
         r_stolen  <= 1'b0;
         r_vnote   <= '0;
         r_vvel    <= '0;
         for (int i = 0; i < NVOICES; i++) begin
            r_note[i] <= '0;
         end
      end else begin
         r_load    <= '0;
         r_release <= '0;
         r_stolen  <= 1'b0;
         if (r_state == ST_COMMIT) begin
            case (r_op)
               OP_ON: begin
                  r_gate[w_target] <= 1'b1;
                  r_note[w_target] <= r_cmd_note;
                  r_load[w_target] <= 1'b1;
                  r_stolen         <= w_steal;
                  r_vnote          <= r_cmd_note;
                  r_vvel           <= r_cmd_vel;
               end
               OP_OFF: begin
                  if (r_match_vld) begin
                     r_gate[r_match_idx]    <= 1'b0;
                     r_release[r_match_idx] <= 1'b1;
                  end
               end
               OP_ALLOFF: begin
                  r_release <= r_gate;
                  r_gate    <= '0;
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Population count of the registered gates
   always_comb begin
      w_active = '0;
      for (int i = 0; i < NVOICES; i++) begin
         w_active = w_active + 5'(r_gate[i]);
      end
   end

   assign voice_load    = r_load;
   assign voice_note    = r_vnote;
   assign voice_vel     = r_vvel;
   assign voice_gate    = r_gate;
   assign voice_release = r_release;
   assign voice_stolen  = r_stolen;
   assign active_count  = w_active;

endmodule
